// File: rtl/risc32i_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | risc32i_pkg                                                           |
// | Shared opcode constants, ALU/immediate encodings and the decoded     |
// | bundle layout for the risc32i decode stage.                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package risc32i_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_t;

   typedef enum logic [2:0] {
      IMM_I    = 3'd0,
      IMM_S    = 3'd1,
      IMM_B    = 3'd2,
      IMM_U    = 3'd3,
      IMM_J    = 3'd4,
      IMM_NONE = 3'd5
   } imm_fmt_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] imm;
      alu_op_t         alu_op;
      logic [2:0]      funct3;
      logic            use_imm;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            branch;
      logic            jump;
      logic            illegal;
   } bundle_t;

   // funct3 -> ALU op for OP / OP-IMM; alt selects SUB/SRA variants
   function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
      alu_op_t op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decode_stage_if                                                       |
// | Fetch-side and execute-side handshake/bundle signals of the decode   |
// | stage. slave = decode stage view, master = surrounding pipeline.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface decode_stage_if;
   import risc32i_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_instr;
   logic [XLEN-1:0] in_pc;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [XLEN-1:0] out_imm;
   alu_op_t         out_alu_op;
   logic [2:0]      out_funct3;
   logic            out_use_imm;
   logic            out_reg_write;
   logic            out_mem_read;
   logic            out_mem_write;
   logic            out_branch;
   logic            out_jump;
   logic            out_illegal;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
             out_alu_op, out_funct3, out_use_imm, out_reg_write, out_mem_read,
             out_mem_write, out_branch, out_jump, out_illegal
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
             out_alu_op, out_funct3, out_use_imm, out_reg_write, out_mem_read,
             out_mem_write, out_branch, out_jump, out_illegal
   );

endinterface
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_gen                                                               |
// | Combinational RV32I immediate extraction for I/S/B/U/J formats.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module imm_gen
   import risc32i_pkg::*;
(
   input  logic [31:7]     instr_i,   // opcode bits never feed an immediate
   input  imm_fmt_t        fmt_i,
   output logic [XLEN-1:0] imm_o
);

   // select and sign-extend the immediate for the requested format
   always_comb begin
      imm_o = '0;
      case (fmt_i)
         IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
         IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
         IMM_U: imm_o = {instr_i[31:12], 12'b0};
         IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
         default: imm_o = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decode_stage                                                          |
// | Registered RV32I decoder: field/flag decode, illegal detection and a |
// | single valid/ready pipeline register with synchronous flush.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module decode_stage
   import risc32i_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   decode_stage_if.slave  bus
);

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   imm_fmt_t   fmt;
   logic [XLEN-1:0] imm;
   bundle_t    bundle_d;
   bundle_t    bundle_q;
   logic       valid_q;
   logic       take_in;

   assign opcode = bus.in_instr[6:0];
   assign f3     = bus.in_instr[14:12];
   assign f7     = bus.in_instr[31:25];

   imm_gen u_imm_gen (
      .instr_i (bus.in_instr[31:7]),
      .fmt_i   (fmt),
      .imm_o   (imm)
   );

   // decode opcode into format, ALU op and control flags; illegal wins last
   always_comb begin
      fmt                = IMM_NONE;
      bundle_d           = '0;
      bundle_d.pc        = bus.in_pc;
      bundle_d.rd        = bus.in_instr[11:7];
      bundle_d.rs1       = bus.in_instr[19:15];
      bundle_d.rs2       = bus.in_instr[24:20];
      bundle_d.funct3    = f3;
      bundle_d.alu_op    = ALU_ADD;
      case (opcode)
         OPC_LUI: begin
            fmt = IMM_U;
            bundle_d.alu_op    = ALU_PASSB;
            bundle_d.use_imm   = 1'b1;
            bundle_d.reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            fmt = IMM_U;
            bundle_d.use_imm   = 1'b1;
            bundle_d.reg_write = 1'b1;
         end
         OPC_JAL: begin
            fmt = IMM_J;
            bundle_d.use_imm   = 1'b1;
            bundle_d.reg_write = 1'b1;
            bundle_d.jump      = 1'b1;
         end
         OPC_JALR: begin
            fmt = IMM_I;
            bundle_d.use_imm   = 1'b1;
            bundle_d.reg_write = 1'b1;
            bundle_d.jump      = 1'b1;
            bundle_d.illegal   = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            fmt = IMM_B;
            bundle_d.alu_op    = ALU_SUB;
            bundle_d.branch    = 1'b1;
            bundle_d.illegal   = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OPC_LOAD: begin
            fmt = IMM_I;
            bundle_d.use_imm   = 1'b1;
            bundle_d.reg_write = 1'b1;
            bundle_d.mem_read  = 1'b1;
            bundle_d.illegal   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         OPC_STORE: begin
            fmt = IMM_S;
            bundle_d.use_imm   = 1'b1;
            bundle_d.mem_write = 1'b1;
            bundle_d.illegal   = (f3 >= 3'b011);
         end
         OPC_OPIMM: begin
            fmt = IMM_I;
            bundle_d.alu_op    = alu_from_f3(f3, (f3 == 3'b101) && bus.in_instr[30]);
            bundle_d.use_imm   = 1'b1;
            bundle_d.reg_write = 1'b1;
            if (f3 == 3'b001)
               bundle_d.illegal = (f7 != 7'h00);
            else if (f3 == 3'b101)
               bundle_d.illegal = (f7 != 7'h00) && (f7 != 7'h20);
         end
         OPC_OP: begin
            bundle_d.alu_op    = alu_from_f3(f3, bus.in_instr[30]);
            bundle_d.reg_write = 1'b1;
            bundle_d.illegal   = !((f7 == 7'h00) ||
                                   ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
         end
         OPC_FENCE: begin
            // executes as a NOP in this in-order core
         end
         default: bundle_d.illegal = 1'b1;
      endcase

      if (bus.in_instr[1:0] != 2'b11)
         bundle_d.illegal = 1'b1;

      bundle_d.imm = imm;

      if (bundle_d.rd == 5'd0)
         bundle_d.reg_write = 1'b0;

      if (bundle_d.illegal) begin
         bundle_d.use_imm   = 1'b0;
         bundle_d.reg_write = 1'b0;
         bundle_d.mem_read  = 1'b0;
         bundle_d.mem_write = 1'b0;
         bundle_d.branch    = 1'b0;
         bundle_d.jump      = 1'b0;
      end
   end

   assign bus.in_ready = !valid_q || bus.out_ready;
   assign take_in      = bus.in_valid && bus.in_ready && !flush;

   // pipeline register: flush beats capture, capture beats drain, stall holds
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         bundle_q <= '0;
      end else if (flush) begin
         valid_q  <= 1'b0;
      end else if (take_in) begin
         valid_q  <= 1'b1;
         bundle_q <= bundle_d;
      end else if (bus.out_ready) begin
         valid_q  <= 1'b0;
      end
   end

   assign bus.out_valid     = valid_q;
   assign bus.out_pc        = bundle_q.pc;
   assign bus.out_rd        = bundle_q.rd;
   assign bus.out_rs1       = bundle_q.rs1;
   assign bus.out_rs2       = bundle_q.rs2;
   assign bus.out_imm       = bundle_q.imm;
   assign bus.out_alu_op    = bundle_q.alu_op;
   assign bus.out_funct3    = bundle_q.funct3;
   assign bus.out_use_imm   = bundle_q.use_imm;
   assign bus.out_reg_write = bundle_q.reg_write;
   assign bus.out_mem_read  = bundle_q.mem_read;
   assign bus.out_mem_write = bundle_q.mem_write;
   assign bus.out_branch    = bundle_q.branch;
   assign bus.out_jump      = bundle_q.jump;
   assign bus.out_illegal   = bundle_q.illegal;

endmodule
`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Registered RV32I instruction decoder for the risc32i core, the decode counterpart of the fetch/encode path. It accepts one 32-bit instruction word plus its PC per handshake, splits it into register indices, a sign-extended immediate and control flags, and presents the result one cycle later through a single pipeline register. It sits between fetch and execute, with valid/ready on both sides and a synchronous flush for taken branches.

## Interface
- XLEN, 32, data/PC width (fixed at 32; not meant to be overridden)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; drops held and incoming instruction
- in_valid  in  1  instruction word valid
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  32  registered in_pc
- out_rd, out_rs1, out_rs2  out  5 each  register indices
- out_imm  out  32  sign-extended immediate
- out_alu_op  out  4  ALU operation code (package enum)
- out_funct3  out  3  raw funct3 (load/store size, branch condition)
- out_use_imm, out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal  out  1 each  control flags

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- in_ready = !out_valid || out_ready (combinational; no input-to-output combinational data path).
- On transfer in: all out_* fields load the decode of in_instr/in_pc; out_valid set.
- On transfer out without transfer in: out_valid clears; data fields hold.
- Stall (out_valid && !out_ready): every out_* field stable.
- Opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, plus FENCE decoded as NOP (all flags 0, legal).
- Immediates per I/S/B/U/J format, bit 31 sign-extends; B/J bit 0 is 0; U is {instr[31:12], 12'b0}.
- ALU ops: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10. LUI → PASSB; AUIPC/loads/stores/JAL/JALR → ADD; branches → SUB.
- out_reg_write forced 0 when rd == 0.
- Illegal: instr[1:0] != 2'b11, unknown opcode, OP funct7 not 0x00/0x20 (0x20 only with ADD/SRL), shift-imm bad funct7, JALR funct3 != 0, branch funct3 010/011, load funct3 011/110/111, store funct3 ≥ 011. Illegal bundle: out_illegal = 1, all other flags 0, still delivered with out_valid.

## Timing
- Latency: 1 cycle; throughput 1 instruction/cycle when out_ready stays high.
- Reset (async assert, any cycle): out_valid = 0, every out_* field = 0, in_ready = 1 from the next evaluation after reset. Bundle in flight is lost.
- flush: next edge out_valid = 0; concurrent in_valid is not taken even though in_ready may be 1. Flush has priority over transfer in and stall.
- Simultaneous transfer out and transfer in: new bundle replaces old in the same edge; no bubble.

## Structure
- Package risc32i_pkg: opcode localparams, alu_op_t enum (values above), imm_fmt_t enum (I, S, B, U, J, NONE).
- Sub-module imm_gen: combinational; instr plus imm_fmt_t in, 32-bit immediate out.
- decode_stage: combinational field/flag decode, illegal check, and the pipeline register plus handshake.

## Test plan
- ADDI x1,x0,5 (0x00500093) → rd 1, rs1 0, imm 5, alu ADD, use_imm 1, reg_write 1, illegal 0, one cycle later.
- SUB x3,x1,x2 (0x402081B3), then LUI x5,0x12345 (0x123452B7) back-to-back → SUB rd3/rs1 1/rs2 2, then PASSB imm 0x12345000; no bubble.
- SW x2,8(x1) (0x0020A423), then BEQ x0,x0,-4 (0xFE000EE3) → imm 8, mem_write 1, reg_write 0; then imm 0xFFFFFFFC, branch 1, alu SUB.
- Backpressure: out_ready 0 for 3 cycles with bundle held → in_ready 0, all outputs unchanged; release → next word accepted same edge.
- 0xFFFFFFFF, and ADD with funct7 0x01 → out_illegal 1, all other flags 0, out_valid 1.
- flush during stall with in_valid 1 → out_valid 0 next cycle, input not captured; rst asserted mid-stream → all outputs 0 immediately.
